// File: rtl/microwave_pkg.sv
// Shared types and widths for the microwave controller slice.
//   state_t    : 2-bit FSM encoding (IDLE=0, COOK=1, PAUSE=2, DONE=3)
//   KEY_W      : one-hot keypad width
//   BCD_W      : digit width
//   key_to_bcd : one-hot to BCD priority encoder, highest set index wins
package microwave_pkg;

  localparam int unsigned KEY_W   = 10;
  localparam int unsigned BCD_W   = 4;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'd0,
    S_COOK  = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Later (higher) indices overwrite earlier ones, so the highest key wins.
  function automatic logic [BCD_W-1:0] key_to_bcd(input logic [KEY_W-1:0] key);
    logic [BCD_W-1:0] bcd;
    bcd = '0;
    for (int i = 0; i < int'(KEY_W); i++) begin
      if (key[i]) bcd = BCD_W'(i);
    end
    return bcd;
  endfunction

endpackage

// File: rtl/keypad_capture.sv
// Keypad front end: registers the raw one-hot keypad, detects the transition
// from "no key" to "some key" and emits one valid strobe with the BCD digit.
// A held key (or chord) produces one capture; all keys must be released
// before the next capture.
// Ports:
//   clock, resetn : clock and asynchronous active-low reset
//   keypad        : raw one-hot keys, bit i = digit i
//   valid         : registered one-cycle capture strobe
//   digit         : registered BCD digit of the last capture
module keypad_capture
  import microwave_pkg::*;
(
  input  logic             clock,
  input  logic             resetn,
  input  logic [KEY_W-1:0] keypad,
  output logic             valid,
  output logic [BCD_W-1:0] digit
);

  logic [KEY_W-1:0] key_q;
  logic             key_seen;
  logic             capture_c;

  // Fire only on the first cycle the registered keypad becomes nonzero.
  assign capture_c = (|key_q) && !key_seen;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_q    <= '0;
      key_seen <= 1'b0;
      valid    <= 1'b0;
      digit    <= '0;
    end else begin
      key_q    <= keypad;
      key_seen <= |key_q;
      valid    <= capture_c;
      if (capture_c) digit <= key_to_bcd(key_q);
    end
  end

endmodule

// File: rtl/cook_controller.sv
// Microwave cook controller: sequences the BCD timer datapath from the panel
// inputs (digit loads, timer clear, 1 s decrement strobe, magnetron enable).
// Optional done beep is built only when CTRL_BEEP_EN is defined; otherwise
// beep is tied low and no beep counter exists.
// Ports:
//   clock, resetn : 100 Hz clock, asynchronous active-low reset
//   keypad        : one-hot digit keys
//   startn        : start button (active low, falling edge acts)
//   stopn, clearn : stop / clear buttons (active low, level)
//   door_closed   : 1 = door closed
//   timer_zero    : datapath timer reads 0:00
//   load_digit    : strobe, shift digit into timer
//   digit         : BCD value accompanying load_digit
//   clear_timer   : strobe, zero the timer
//   count_en      : strobe, decrement timer by one second
//   mag_on        : magnetron enable, high exactly while in COOK
//   state         : current FSM state (debug)
//   beep          : done indication
module cook_controller
  import microwave_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100,
  parameter int unsigned BEEP_LEN = 300
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [KEY_W-1:0]   keypad,
  input  logic               startn,
  input  logic               stopn,
  input  logic               clearn,
  input  logic               door_closed,
  input  logic               timer_zero,
  output logic               load_digit,
  output logic [BCD_W-1:0]   digit,
  output logic               clear_timer,
  output logic               count_en,
  output logic               mag_on,
  output logic [STATE_W-1:0] state,
  output logic               beep
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_t           state_q, state_n;
  logic [PRE_W-1:0] presc_q, presc_n;
  logic             load_n, clear_n, count_n;

  logic             cap_valid;
  logic [BCD_W-1:0] cap_digit;

  logic             start_q, start_d;
  logic             start_edge;

  keypad_capture u_keypad_capture (
    .clock  (clock),
    .resetn (resetn),
    .keypad (keypad),
    .valid  (cap_valid),
    .digit  (cap_digit)
  );

  // Start button press history; an event is the first pressed cycle only.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      start_q <= 1'b0;
      start_d <= 1'b0;
    end else begin
      start_q <= ~startn;
      start_d <= start_q;
    end
  end

  assign start_edge = start_q && !start_d;

  // State, prescaler and registered strobes.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      load_digit  <= 1'b0;
      digit       <= '0;
      clear_timer <= 1'b0;
      count_en    <= 1'b0;
      mag_on      <= 1'b0;
    end else begin
      state_q     <= state_n;
      presc_q     <= presc_n;
      load_digit  <= load_n;
      if (load_n) digit <= cap_digit;
      clear_timer <= clear_n;
      count_en    <= count_n;
      mag_on      <= (state_n == S_COOK);
    end
  end

  // Next state and strobes. Prescaler defaults to 0 so every COOK entry
  // restarts the partial second and it holds 0 outside COOK.
  always_comb begin
    state_n = state_q;
    presc_n = '0;
    load_n  = 1'b0;
    clear_n = 1'b0;
    count_n = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!clearn) begin
          clear_n = 1'b1;
        end else begin
          if (cap_valid) load_n = 1'b1;
          if (start_edge && door_closed && !timer_zero) state_n = S_COOK;
        end
      end
      S_COOK: begin
        if (!clearn) begin
          state_n = S_IDLE;
          clear_n = 1'b1;
        end else if (!door_closed || !stopn) begin
          state_n = S_PAUSE;
        end else if (timer_zero) begin
          state_n = S_DONE;
        end else if (presc_q == PRE_LAST) begin
          count_n = 1'b1;
        end else begin
          presc_n = presc_q + PRE_W'(1);
        end
      end
      S_PAUSE: begin
        if (!clearn) begin
          state_n = S_IDLE;
          clear_n = 1'b1;
        end else if (start_edge && door_closed && stopn) begin
          state_n = S_COOK;
        end
      end
      S_DONE: begin
        // Timer is already zero here, so leaving never needs clear_timer.
        if (!clearn || !door_closed) begin
          state_n = S_IDLE;
        end else if (cap_valid) begin
          state_n = S_IDLE;
          load_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign state = state_q;

`ifdef CTRL_BEEP_EN
  localparam int unsigned BEEP_W = $clog2(BEEP_LEN + 1);

  logic [BEEP_W-1:0] beep_cnt;

  // Load on DONE entry, then beep while the count drains; leaving DONE cuts it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      beep_cnt <= '0;
      beep     <= 1'b0;
    end else if (state_n != S_DONE) begin
      beep_cnt <= '0;
      beep     <= 1'b0;
    end else if (state_q != S_DONE) begin
      beep_cnt <= BEEP_W'(BEEP_LEN);
      beep     <= 1'b0;
    end else if (beep_cnt != '0) begin
      beep_cnt <= beep_cnt - BEEP_W'(1);
      beep     <= 1'b1;
    end else begin
      beep     <= 1'b0;
    end
  end
`else
  logic unused_beep_len;
  assign unused_beep_len = ^32'(BEEP_LEN);
  assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_cook_controller.sv
// Scoreboard bench for cook_controller (TICK_DIV=4, BEEP_LEN=3).
// Stimulus pushes expectations; the negedge monitor pops and compares.
module tb_cook_controller;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned BEEP_LEN = 3;
`ifdef CTRL_BEEP_EN
  localparam logic BEEP_ON = 1'b1;
`else
  localparam logic BEEP_ON = 1'b0;
`endif

  logic       clock;
  logic       resetn;
  logic [9:0] keypad;
  logic       startn, stopn, clearn, door_closed, timer_zero;
  logic       load_digit, clear_timer, count_en, mag_on, beep;
  logic [3:0] digit;
  logic [1:0] state;

  cook_controller #(.TICK_DIV(TICK_DIV), .BEEP_LEN(BEEP_LEN)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .keypad      (keypad),
    .startn      (startn),
    .stopn       (stopn),
    .clearn      (clearn),
    .door_closed (door_closed),
    .timer_zero  (timer_zero),
    .load_digit  (load_digit),
    .digit       (digit),
    .clear_timer (clear_timer),
    .count_en    (count_en),
    .mag_on      (mag_on),
    .state       (state),
    .beep        (beep)
  );

  typedef struct packed {
    logic [1:0] st;
    logic       mag;
    logic       cnt;
    logic       bp;
    logic       rst_chk;
  } snap_t;

  snap_t      snap_q[$];
  string      name_q[$];
  logic [3:0] load_q[$];
  logic       clear_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         done = 1'b0;

  snap_t      s;
  string      n;
  logic [3:0] e;
  logic       c;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Monitor / scoreboard.
  always @(negedge clock) begin
    while (snap_q.size() != 0) begin
      s = snap_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (state !== s.st || mag_on !== s.mag || count_en !== s.cnt || beep !== s.bp ||
          (s.rst_chk && (load_digit !== 1'b0 || clear_timer !== 1'b0 || digit !== 4'd0))) begin
        errors++;
        $display("FAIL %s: got state=%0d mag_on=%b count_en=%b beep=%b load=%b clear=%b digit=%0d, want state=%0d mag_on=%b count_en=%b beep=%b",
                 n, state, mag_on, count_en, beep, load_digit, clear_timer, digit,
                 s.st, s.mag, s.cnt, s.bp);
      end
    end
    if (resetn) begin
      checks++;
      if (mag_on !== (state == 2'd1) || (count_en === 1'b1 && state != 2'd1)) begin
        errors++;
        $display("FAIL mag_state: got mag_on=%b count_en=%b state=%0d, want mag_on=%b and count_en only in COOK",
                 mag_on, count_en, state, (state == 2'd1));
      end
      if (load_digit === 1'b1) begin
        checks++;
        if (load_q.size() == 0) begin
          errors++;
          $display("FAIL load_digit: got unexpected load digit=%0d, want none", digit);
        end else begin
          e = load_q.pop_front();
          if (digit !== e) begin
            errors++;
            $display("FAIL load_digit: got digit=%0d, want %0d", digit, e);
          end
        end
      end
      if (clear_timer === 1'b1) begin
        checks++;
        if (clear_q.size() == 0) begin
          errors++;
          $display("FAIL clear_timer: got unexpected pulse, want none");
        end else begin
          c = clear_q.pop_front();
        end
      end
    end
    if (done) begin
      checks++;
      if (load_q.size() != 0) begin
        errors++;
        $display("FAIL load_missing: got %0d loads outstanding, want 0", load_q.size());
      end
      checks++;
      if (clear_q.size() != 0) begin
        errors++;
        $display("FAIL clear_missing: got %0d clears outstanding, want 0", clear_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_snap(input string nm, input logic [1:0] st, input logic mag,
                             input logic cnt, input logic bp);
    snap_t t;
    t = '{st: st, mag: mag, cnt: cnt, bp: bp, rst_chk: 1'b0};
    snap_q.push_back(t);
    name_q.push_back(nm);
  endtask

  task automatic expect_reset(input string nm);
    snap_t t;
    t = '{st: 2'd0, mag: 1'b0, cnt: 1'b0, bp: 1'b0, rst_chk: 1'b1};
    snap_q.push_back(t);
    name_q.push_back(nm);
  endtask

  // startn low for two cycles: ends in the cycle the state would reach COOK.
  task automatic press_start();
    startn = 1'b0;
    step();
    step();
    startn = 1'b1;
  endtask

  // Expect COOK now, then no tick for 3 cycles and a tick on the 4th.
  task automatic cook_entry(input string nm);
    expect_snap({nm, "_entry"}, 2'd1, 1'b1, 1'b0, 1'b0);
    repeat (3) begin
      step();
      expect_snap({nm, "_pretick"}, 2'd1, 1'b1, 1'b0, 1'b0);
    end
    step();
    expect_snap({nm, "_tick"}, 2'd1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic press_mask(input logic [9:0] mask, input logic [3:0] dig, input int hold);
    load_q.push_back(dig);
    keypad = mask;
    repeat (hold) step();
    keypad = '0;
    repeat (5) step();
    expect_snap("idle_after_key", 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    keypad = '0;
    startn = 1'b1;
    stopn = 1'b1;
    clearn = 1'b1;
    door_closed = 1'b0;
    timer_zero = 1'b0;
    step();
    step();
    expect_reset("reset_state");
    @(negedge clock);
    #2 resetn = 1'b1;
    step();

    // Keys 3, 5, 9, each held 10 cycles.
    press_mask(10'b1 << 3, 4'd3, 10);
    press_mask(10'b1 << 5, 4'd5, 10);
    press_mask(10'b1 << 9, 4'd9, 10);
    // Chord: highest index wins.
    press_mask(10'h024, 4'd5, 10);

    // Start with door open is ignored.
    press_start();
    step();
    expect_snap("start_door_open", 2'd0, 1'b0, 1'b0, 1'b0);

    // Start with timer at zero is ignored.
    door_closed = 1'b1;
    timer_zero = 1'b1;
    step();
    press_start();
    step();
    expect_snap("start_timer_zero", 2'd0, 1'b0, 1'b0, 1'b0);
    timer_zero = 1'b0;
    step();

    // Cook, then timer_zero in the would-be wrap cycle.
    press_start();
    cook_entry("cook1");
    repeat (3) step();
    timer_zero = 1'b1;
    step();
    expect_snap("done_entry", 2'd3, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      step();
      expect_snap("done_beep", 2'd3, 1'b0, 1'b0, BEEP_ON);
    end
    step();
    expect_snap("done_beep_end", 2'd3, 1'b0, 1'b0, 1'b0);
    door_closed = 1'b0;
    step();
    expect_snap("done_door_open", 2'd0, 1'b0, 1'b0, 1'b0);
    timer_zero = 1'b0;
    door_closed = 1'b1;
    step();

    // Ten ticks, then door open pauses.
    press_start();
    cook_entry("cook2");
    repeat (9) begin
      repeat (3) begin
        step();
        expect_snap("cook2_gap", 2'd1, 1'b1, 1'b0, 1'b0);
      end
      step();
      expect_snap("cook2_tick", 2'd1, 1'b1, 1'b1, 1'b0);
    end
    door_closed = 1'b0;
    step();
    expect_snap("pause_door", 2'd2, 1'b0, 1'b0, 1'b0);
    repeat (6) begin
      step();
      expect_snap("pause_hold", 2'd2, 1'b0, 1'b0, 1'b0);
    end
    press_start();
    step();
    expect_snap("pause_start_door_open", 2'd2, 1'b0, 1'b0, 1'b0);
    door_closed = 1'b1;
    step();
    expect_snap("pause_door_closed", 2'd2, 1'b0, 1'b0, 1'b0);
    press_start();
    cook_entry("resume_door");

    // Stop pauses; start while stop held is ignored.
    stopn = 1'b0;
    step();
    expect_snap("pause_stop", 2'd2, 1'b0, 1'b0, 1'b0);
    press_start();
    step();
    expect_snap("pause_start_stop_low", 2'd2, 1'b0, 1'b0, 1'b0);
    stopn = 1'b1;
    step();
    expect_snap("pause_stop_released", 2'd2, 1'b0, 1'b0, 1'b0);
    press_start();
    cook_entry("resume_stop");

    // Clear together with a start edge in COOK.
    clear_q.push_back(1'b1);
    startn = 1'b0;
    step();
    clearn = 1'b0;
    step();
    clearn = 1'b1;
    startn = 1'b1;
    expect_snap("clear_cook", 2'd0, 1'b0, 1'b0, 1'b0);
    step();
    expect_snap("clear_cook_idle", 2'd0, 1'b0, 1'b0, 1'b0);
    press_mask(10'h080, 4'd7, 20);

    // Key capture and clear in the same IDLE cycle: clear wins, key dropped.
    clear_q.push_back(1'b1);
    keypad = 10'b1 << 2;
    step();
    step();
    clearn = 1'b0;
    step();
    clearn = 1'b1;
    repeat (5) step();
    keypad = '0;
    repeat (4) step();
    expect_snap("key_clear_idle", 2'd0, 1'b0, 1'b0, 1'b0);

    // DONE with beep, key 1 cuts it short and is loaded.
    press_start();
    expect_snap("cook3_entry", 2'd1, 1'b1, 1'b0, 1'b0);
    timer_zero = 1'b1;
    step();
    expect_snap("done2_entry", 2'd3, 1'b0, 1'b0, 1'b0);
    load_q.push_back(4'd1);
    keypad = 10'b1 << 1;
    step();
    expect_snap("done2_beep1", 2'd3, 1'b0, 1'b0, BEEP_ON);
    step();
    expect_snap("done2_beep2", 2'd3, 1'b0, 1'b0, BEEP_ON);
    step();
    expect_snap("done2_key_exit", 2'd0, 1'b0, 1'b0, 1'b0);
    keypad = '0;
    timer_zero = 1'b0;
    repeat (4) step();

    // Asynchronous reset in the middle of COOK.
    press_start();
    expect_snap("cook4_entry", 2'd1, 1'b1, 1'b0, 1'b0);
    step();
    step();
    #1 resetn = 1'b0;
    expect_reset("async_reset_cook");
    @(negedge clock);
    #2 resetn = 1'b1;
    step();
    expect_snap("after_reset", 2'd0, 1'b0, 1'b0, 1'b0);

    repeat (3) step();
    done = 1'b1;
  end

endmodule
